// File: rtl/manchester_frame_scheduler_if.sv
// Byte-stream bundle between NUM_SRC AXI-Stream byte sources, the frame scheduler and the serializer.
// slave = scheduler side, master = source/serializer environment side.
interface manchester_frame_scheduler_if #(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC-1:0]   s_axis_tvalid;
    logic [8*NUM_SRC-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]   s_axis_tready;
    logic                 m_axis_tvalid;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tready;

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata
    );
endinterface

// File: rtl/manchester_frame_scheduler.sv
// Round-robin framer: preamble, SFD, escaped payload and idle gap per granted source; first AA one cycle after request.
// Single output byte register; upstream tready only while that slot frees, so downstream stalls propagate back.
module manchester_frame_scheduler #(
    parameter int NUM_SRC      = 2,
    parameter int FRAME_SIZE   = 4,
    parameter int PREAMBLE_LEN = 2,
    parameter int GAP_CYCLES   = 4,
    localparam int GW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    manchester_frame_scheduler_if.slave axis,
    output logic [GW-1:0]               grant_id,
    output logic                        frame_busy
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, PAYLOAD, ESC2, GAP} state_t;

    state_t           state_q, state_d;
    logic             m_vld_q, m_vld_d;
    logic [7:0]       m_dat_q, m_dat_d;
    logic [7:0]       esc_q, esc_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_q, rr_d, rr_next;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic             pick_vld;
    logic [GW-1:0]    pick_idx, cand;
    logic             slot_free, accept, src_vld, frame_done;
    logic [7:0]       src_dat;
    logic [NUM_SRC-1:0] s_rdy;

    assign slot_free  = !m_vld_q || axis.m_axis_tready;
    assign accept     = m_vld_q && axis.m_axis_tready;
    assign src_vld    = axis.s_axis_tvalid[grant_q];
    assign src_dat    = axis.s_axis_tdata[8*int'(grant_q) +: 8];
    assign frame_done = (cnt_q == 8'(FRAME_SIZE));
    assign rr_next    = (grant_q == GW'(NUM_SRC-1)) ? '0 : grant_q + 1'b1;

    // Scan from the farthest offset down so the requester nearest the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_SRC-1; i >= 0; i--) begin
            cand = GW'((int'(rr_q) + i) % NUM_SRC);
            if (axis.s_axis_tvalid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        esc_d   = esc_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        s_rdy   = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    m_vld_d = 1'b1;
                    m_dat_d = 8'hAA;
                    cnt_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (accept) begin
                    if (cnt_q == 8'(PREAMBLE_LEN-1)) begin
                        m_dat_d = 8'hD5;
                        cnt_d   = '0;
                        state_d = SFD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            SFD: begin
                if (accept) begin
                    m_vld_d = 1'b0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) m_vld_d = 1'b0;
                // cnt counts source bytes; once all are taken we only wait for the register to drain.
                if (frame_done) begin
                    if (slot_free) begin
                        if (GAP_CYCLES == 0) begin
                            busy_d  = 1'b0;
                            rr_d    = rr_next;
                            state_d = IDLE;
                        end else begin
                            gap_d   = 8'd1;
                            state_d = GAP;
                        end
                    end
                end else begin
                    s_rdy[grant_q] = slot_free;
                    if (slot_free && src_vld) begin
                        cnt_d   = cnt_q + 8'd1;
                        m_vld_d = 1'b1;
                        m_dat_d = src_dat;
                        if (src_dat == 8'hD5) begin
                            m_dat_d = 8'hE5;
                            esc_d   = 8'hF5;
                            state_d = ESC2;
                        end else if (src_dat == 8'hE5) begin
                            m_dat_d = 8'hE5;
                            esc_d   = 8'hE5;
                            state_d = ESC2;
                        end
                    end
                end
            end
            ESC2: begin
                if (slot_free) begin
                    m_vld_d = 1'b1;
                    m_dat_d = esc_q;
                    state_d = PAYLOAD;
                end
            end
            GAP: begin
                if (gap_q == 8'(GAP_CYCLES)) begin
                    busy_d  = 1'b0;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            m_vld_q <= 1'b0;
            m_dat_q <= '0;
            esc_q   <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            m_vld_q <= m_vld_d;
            m_dat_q <= m_dat_d;
            esc_q   <= esc_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign axis.s_axis_tready = s_rdy;
    assign axis.m_axis_tvalid = m_vld_q;
    assign axis.m_axis_tdata  = m_dat_q;
    assign grant_id           = grant_q;
    assign frame_busy         = busy_q;
endmodule

// File: tb/tb_manchester_frame_scheduler.sv
// Bench for manchester_frame_scheduler: directed and random frames against a frame-level reference model.
module tb_manchester_frame_scheduler;
    localparam int NUM_SRC      = 2;
    localparam int FRAME_SIZE   = 4;
    localparam int PREAMBLE_LEN = 2;
    localparam int GAP_CYCLES   = 4;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [0:0] grant_id;
    logic       frame_busy;

    manchester_frame_scheduler_if #(.NUM_SRC(NUM_SRC)) bus();

    manchester_frame_scheduler #(
        .NUM_SRC(NUM_SRC), .FRAME_SIZE(FRAME_SIZE),
        .PREAMBLE_LEN(PREAMBLE_LEN), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .aclk(aclk), .areset(areset), .axis(bus.slave),
        .grant_id(grant_id), .frame_busy(frame_busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, last_acc_cyc = 0, frame_hs = 0, rr_m = 0;
    logic [7:0] src_q [NUM_SRC][$];
    logic [7:0] mdl_q [NUM_SRC][$];
    logic [8:0] exp_q [$];
    int exp_gnt [$];
    int hold [NUM_SRC];
    int fr_cnt [NUM_SRC];
    int rdy_mode = 0, low_cnt = 0, stall_after = -1;
    bit esc_stall = 0, chk_stall = 0;
    logic prev_vld = 0, prev_rdy = 0, prev_busy = 0;
    logic [7:0] prev_dat = 0;
    logic [NUM_SRC-1:0] prev_tv = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame bytes given MSB-first in one 32-bit word.
    task automatic add_frame(input int s, input logic [31:0] w);
        logic [7:0] b;
        for (int k = 0; k < FRAME_SIZE; k++) begin
            b = w[31-8*k -: 8];
            src_q[s].push_back(b);
            mdl_q[s].push_back(b);
        end
    endtask

    // Reference: frame-level round robin over sources with pending frames, escape rules as plain substitution.
    task automatic plan();
        int pick;
        logic [7:0] b;
        forever begin
            pick = -1;
            for (int k = 0; k < NUM_SRC; k++)
                if (pick < 0 && mdl_q[(rr_m + k) % NUM_SRC].size() > 0) pick = (rr_m + k) % NUM_SRC;
            if (pick < 0) break;
            exp_gnt.push_back(pick);
            for (int k = 0; k < PREAMBLE_LEN; k++) exp_q.push_back(9'h0AA);
            exp_q.push_back(9'h0D5);
            for (int k = 0; k < FRAME_SIZE; k++) begin
                b = mdl_q[pick].pop_front();
                if (b == 8'hD5) begin exp_q.push_back(9'h0E5); exp_q.push_back(9'h0F5); end
                else if (b == 8'hE5) begin exp_q.push_back(9'h0E5); exp_q.push_back(9'h0E5); end
                else exp_q.push_back({1'b0, b});
            end
            rr_m = (pick + 1) % NUM_SRC;
        end
    endtask

    task automatic cycle();
        logic r;
        int h0, e;
        logic [NUM_SRC-1:0] gm, tv;
        @(negedge aclk);
        case (rdy_mode)
            1:       r = (cyc % 2 == 0);
            2:       r = ($urandom_range(0, 3) != 0);
            default: r = 1'b1;
        endcase
        if (low_cnt > 0) begin r = 1'b0; low_cnt--; end
        bus.m_axis_tready = r;
        h0 = hold[0];
        for (int i = 0; i < NUM_SRC; i++) begin
            tv[i] = (src_q[i].size() > 0) && (hold[i] == 0);
            if (hold[i] > 0) hold[i]--;
            bus.s_axis_tvalid[i] = tv[i];
            bus.s_axis_tdata[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
        #1;
        gm = '0;
        if (frame_busy) gm[grant_id] = 1'b1;
        chk("tready_onehot0", 32'($onehot0(bus.s_axis_tready)), 1);
        chk("tready_owner", 32'(bus.s_axis_tready & ~gm), 0);
        if (prev_vld && !prev_rdy) begin
            chk("stall_vld_held", bus.m_axis_tvalid, 1);
            chk("stall_dat_held", bus.m_axis_tdata, prev_dat);
        end
        if (chk_stall && h0 > 0 && h0 <= 4) chk("src_stall_vld_low", bus.m_axis_tvalid, 0);
        if (!prev_busy && frame_busy) begin
            e = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : -1;
            chk("grant_id", grant_id, e);
            chk("first_aa_vld", bus.m_axis_tvalid, 1);
            chk("first_aa_dat", bus.m_axis_tdata, 8'hAA);
            chk("request_prev_cycle", prev_tv[grant_id], 1);
        end
        if (prev_busy && !frame_busy) begin
            chk("gap_len", cyc - last_acc_cyc, GAP_CYCLES + 1);
            chk("hs_per_frame", frame_hs, FRAME_SIZE);
            frame_hs = 0;
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 32'h100;
            chk("out_byte", {24'h0, bus.m_axis_tdata}, e);
            last_acc_cyc = cyc;
            if (esc_stall && bus.m_axis_tdata == 8'hE5) begin low_cnt = 5; esc_stall = 0; end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (tv[i] && bus.s_axis_tready[i]) begin
                void'(src_q[i].pop_front());
                frame_hs++;
                fr_cnt[i] = (fr_cnt[i] + 1) % FRAME_SIZE;
                if (i == 0 && stall_after >= 0 && fr_cnt[0] == stall_after) begin
                    hold[0] = 6;
                    stall_after = -1;
                end
            end
        end
        prev_vld  = bus.m_axis_tvalid;
        prev_rdy  = bus.m_axis_tready;
        prev_dat  = bus.m_axis_tdata;
        prev_busy = frame_busy;
        prev_tv   = tv;
        cyc++;
    endtask

    task automatic run_frames(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || frame_busy) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_in_budget"}, 32'(n < budget), 1);
        chk({tag, "_all_out"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_m_tvalid"}, bus.m_axis_tvalid, 0);
        chk({tag, "_m_tdata"}, bus.m_axis_tdata, 0);
        chk({tag, "_s_tready"}, bus.s_axis_tready, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_frame_busy"}, frame_busy, 0);
    endtask

    initial begin
        int nf, n;
        logic [31:0] w;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin hold[i] = 0; fr_cnt[i] = 0; end
        repeat (3) @(negedge aclk);
        check_reset_vals("reset");
        areset = 1'b0;

        // Plain frame from source 0.
        add_frame(0, 32'hF00FAAAA);
        plan();
        run_frames("plain", 100);

        // Escaping: D5 and E5 in payload, second frame from source 1.
        add_frame(0, 32'hF00FAAD5);
        add_frame(1, 32'h12E53456);
        plan();
        run_frames("escape", 200);

        // Round robin with both sources continuously valid.
        add_frame(0, 32'h11121314);
        add_frame(0, 32'h11121314);
        add_frame(1, 32'h21222324);
        plan();
        run_frames("round_robin", 300);

        // Downstream toggling plus a 5-cycle stall right after the escape lead byte.
        rdy_mode = 1;
        esc_stall = 1;
        add_frame(1, 32'hD577E501);
        add_frame(0, 32'h5AD50102);
        plan();
        run_frames("backpressure", 300);

        // Source 0 pauses 6 cycles after two payload bytes while source 1 waits.
        rdy_mode = 0;
        stall_after = 2;
        chk_stall = 1;
        add_frame(0, 32'hA1A2A3A4);
        add_frame(1, 32'hB1B2B3B4);
        plan();
        run_frames("src_stall", 300);
        chk_stall = 0;

        // Random payloads biased towards escape bytes, random downstream ready.
        rdy_mode = 2;
        for (int s = 0; s < NUM_SRC; s++) begin
            nf = $urandom_range(2, 4);
            for (int f = 0; f < nf; f++) begin
                for (int k = 0; k < FRAME_SIZE; k++) begin
                    case ($urandom_range(0, 3))
                        0:       w[31-8*k -: 8] = 8'hD5;
                        1:       w[31-8*k -: 8] = 8'hE5;
                        2:       w[31-8*k -: 8] = 8'hAA;
                        default: w[31-8*k -: 8] = 8'($urandom);
                    endcase
                end
                add_frame(s, w);
            end
        end
        plan();
        run_frames("random", 3000);

        // Asynchronous reset in the middle of a payload.
        rdy_mode = 0;
        add_frame(1, 32'hC1C2C3C4);
        add_frame(0, 32'hD1D2D3D4);
        plan();
        n = 0;
        while (frame_hs < 2 && n < 200) begin cycle(); n++; end
        chk("reset_reached_payload", 32'(n < 200), 1);
        #2 areset = 1'b1;
        #1 check_reset_vals("midframe_reset");
        for (int i = 0; i < NUM_SRC; i++) begin
            src_q[i].delete(); mdl_q[i].delete(); hold[i] = 0; fr_cnt[i] = 0;
        end
        exp_q.delete();
        exp_gnt.delete();
        rr_m = 0;
        frame_hs = 0;
        prev_vld = 0; prev_rdy = 0; prev_busy = 0; prev_tv = '0;
        bus.s_axis_tvalid = '0;
        @(negedge aclk);
        check_reset_vals("reset_held");
        areset = 1'b0;

        add_frame(1, 32'h01020304);
        add_frame(0, 32'h0A0B0C0D);
        plan();
        run_frames("after_reset", 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
